// File: rtl/busqueda_frame_sequencer.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// busqueda_frame_sequencer
//
// Frame-level controller for the busqueda motion-search engine and its two
// pixel RAMs (ref, act). Each incoming frame is loaded into the act RAM, then
// busqueda is started and awaited, then act is copied into ref so the current
// frame becomes the next reference. The very first frame has no reference to
// search against, so it goes straight from LOAD to COPY.
//
// The sequencer owns both RAM write ports and the act RAM read port, and
// arbitrates them between the pixel loader, the act->ref copier and busqueda.
//
// Ports
//   i_clk, i_reset_n           clock, synchronous active-low reset
//   i_enable                   run frames (sampled in IDLE and at end of COPY)
//   i_pix_data/valid, o_pix_ready   raster-order pixel stream (valid&ready)
//   o_search_start             1-cycle start pulse to busqueda
//   i_search_idle/finish       busqueda status
//   i_s_wren/wraddr/data_*     busqueda write requests (ref, act)
//   i_s_rdaddr_act             busqueda act read address
//   o_ram_wren/wraddr/data_*   registered RAM write ports (ref, act)
//   o_ram_rdaddr_act           act RAM read address (combinational)
//   i_ram_q_act                act RAM read data, 1-cycle latency
//   o_frame_count              frames completed, wraps
//   o_seq_state                IDLE=0 LOAD=1 START=2 WAIT=3 COPY=4
//   o_conflict                 sticky: busqueda write seen outside WAIT
// -----------------------------------------------------------------------------
module busqueda_frame_sequencer #(
    parameter int unsigned MSBI        = 13,
    parameter int unsigned DW          = 9,
    parameter int unsigned FRAME_WORDS = 8192
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_enable,
    input  logic [DW-1:0]   i_pix_data,
    input  logic            i_pix_valid,
    output logic            o_pix_ready,
    output logic            o_search_start,
    input  logic            i_search_idle,
    input  logic            i_search_finish,
    input  logic            i_s_wren_ref,
    input  logic            i_s_wren_act,
    input  logic [MSBI:0]   i_s_wraddr_ref,
    input  logic [MSBI:0]   i_s_wraddr_act,
    input  logic [DW-1:0]   i_s_data_ref,
    input  logic [DW-1:0]   i_s_data_act,
    input  logic [MSBI:0]   i_s_rdaddr_act,
    output logic            o_ram_wren_ref,
    output logic            o_ram_wren_act,
    output logic [MSBI:0]   o_ram_wraddr_ref,
    output logic [MSBI:0]   o_ram_wraddr_act,
    output logic [DW-1:0]   o_ram_data_ref,
    output logic [DW-1:0]   o_ram_data_act,
    output logic [MSBI:0]   o_ram_rdaddr_act,
    input  logic [DW-1:0]   i_ram_q_act,
    output logic [15:0]     o_frame_count,
    output logic [2:0]      o_seq_state,
    output logic            o_conflict
);

    localparam int unsigned AW = MSBI + 1;
    localparam logic [MSBI:0] LastAddr = AW'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StCopy  = 3'd4
    } state_e;

    state_e          r_state, w_state_d;
    logic [MSBI:0]   r_cnt, w_cnt_d;          // shared LOAD write / COPY read address
    logic            r_rd_vld, w_rd_vld_d;    // a COPY read was issued last cycle
    logic [MSBI:0]   r_rd_addr, w_rd_addr_d;  // address of that read
    logic            r_rd_done, w_rd_done_d;  // last COPY read already issued
    logic            r_ref_valid, w_ref_valid_d;
    logic [15:0]     r_frame_count, w_frame_count_d;
    logic            r_conflict, w_conflict_d;

    logic            r_wren_ref, w_wren_ref_d;
    logic            r_wren_act, w_wren_act_d;
    logic [MSBI:0]   r_wraddr_ref, w_wraddr_ref_d;
    logic [MSBI:0]   r_wraddr_act, w_wraddr_act_d;
    logic [DW-1:0]   r_data_ref, w_data_ref_d;
    logic [DW-1:0]   r_data_act, w_data_act_d;

    logic            w_pix_ready;
    logic            w_search_start;

    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_rd_vld_d      = 1'b0;
        w_rd_addr_d     = r_rd_addr;
        w_rd_done_d     = r_rd_done;
        w_ref_valid_d   = r_ref_valid;
        w_frame_count_d = r_frame_count;
        // Busqueda writes outside WAIT are dropped and flagged until reset.
        w_conflict_d    = r_conflict |
                          ((i_s_wren_ref | i_s_wren_act) && (r_state != StWait));
        w_wren_ref_d    = 1'b0;
        w_wren_act_d    = 1'b0;
        w_wraddr_ref_d  = '0;
        w_wraddr_act_d  = '0;
        w_data_ref_d    = '0;
        w_data_act_d    = '0;
        w_pix_ready     = 1'b0;
        w_search_start  = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_enable) begin
                    w_state_d = StLoad;
                    w_cnt_d   = '0;
                end
            end
            StLoad: begin
                w_pix_ready = 1'b1;
                if (i_pix_valid) begin
                    w_wren_act_d   = 1'b1;
                    w_wraddr_act_d = r_cnt;
                    w_data_act_d   = i_pix_data;
                    if (r_cnt == LastAddr) begin
                        if (r_ref_valid) begin
                            w_state_d = StStart;
                        end else begin
                            // No reference yet: nothing to search against.
                            w_state_d   = StCopy;
                            w_cnt_d     = '0;
                            w_rd_done_d = 1'b0;
                        end
                    end else begin
                        w_cnt_d = r_cnt + AW'(1);
                    end
                end
            end
            StStart: begin
                if (i_search_idle) begin
                    w_search_start = 1'b1;
                    w_state_d      = StWait;
                end
            end
            StWait: begin
                w_wren_ref_d   = i_s_wren_ref;
                w_wraddr_ref_d = i_s_wraddr_ref;
                w_data_ref_d   = i_s_data_ref;
                w_wren_act_d   = i_s_wren_act;
                w_wraddr_act_d = i_s_wraddr_act;
                w_data_act_d   = i_s_data_act;
                if (i_search_finish) begin
                    w_state_d   = StCopy;
                    w_cnt_d     = '0;
                    w_rd_done_d = 1'b0;
                end
            end
            StCopy: begin
                // Read stage: issue act[cnt] until the last address is requested.
                if (!r_rd_done) begin
                    w_rd_vld_d  = 1'b1;
                    w_rd_addr_d = r_cnt;
                    if (r_cnt == LastAddr) begin
                        w_rd_done_d = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + AW'(1);
                    end
                end
                // Write stage: read data arrives one cycle after its address.
                if (r_rd_vld) begin
                    w_wren_ref_d   = 1'b1;
                    w_wraddr_ref_d = r_rd_addr;
                    w_data_ref_d   = i_ram_q_act;
                    if (r_rd_done) begin
                        w_ref_valid_d   = 1'b1;
                        w_frame_count_d = r_frame_count + 16'd1;
                        w_cnt_d         = '0;
                        w_state_d       = i_enable ? StLoad : StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_rd_vld      <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_done     <= 1'b0;
            r_ref_valid   <= 1'b0;
            r_frame_count <= '0;
            r_conflict    <= 1'b0;
            r_wren_ref    <= 1'b0;
            r_wren_act    <= 1'b0;
            r_wraddr_ref  <= '0;
            r_wraddr_act  <= '0;
            r_data_ref    <= '0;
            r_data_act    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_rd_vld      <= w_rd_vld_d;
            r_rd_addr     <= w_rd_addr_d;
            r_rd_done     <= w_rd_done_d;
            r_ref_valid   <= w_ref_valid_d;
            r_frame_count <= w_frame_count_d;
            r_conflict    <= w_conflict_d;
            r_wren_ref    <= w_wren_ref_d;
            r_wren_act    <= w_wren_act_d;
            r_wraddr_ref  <= w_wraddr_ref_d;
            r_wraddr_act  <= w_wraddr_act_d;
            r_data_ref    <= w_data_ref_d;
            r_data_act    <= w_data_act_d;
        end
    end

    assign o_pix_ready      = w_pix_ready;
    assign o_search_start   = w_search_start;
    assign o_ram_wren_ref   = r_wren_ref;
    assign o_ram_wren_act   = r_wren_act;
    assign o_ram_wraddr_ref = r_wraddr_ref;
    assign o_ram_wraddr_act = r_wraddr_act;
    assign o_ram_data_ref   = r_data_ref;
    assign o_ram_data_act   = r_data_act;
    assign o_ram_rdaddr_act = (r_state == StCopy) ? r_cnt : i_s_rdaddr_act;
    assign o_frame_count    = r_frame_count;
    assign o_seq_state      = r_state;
    assign o_conflict       = r_conflict;

endmodule
